// File: rtl/div_32.sv
// ---------------------------------------------------------------------------
// div_32 : multi-cycle radix-2 restoring integer divider (DIV / DIVU).
//
// One trial subtraction per clock. A request is accepted in IDLE, the
// magnitudes are divided in RUN (WIDTH cycles), the signs are applied in FIX,
// and DONE reports the result for one cycle. quotient goes to LO and
// remainder goes to HI.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset (aborts any operation)
//   i_start       request, only sampled in IDLE
//   i_sign        1 = signed divide, 0 = unsigned; latched with i_start
//   i_dividend    dividend, latched on accepted start
//   i_divisor     divisor, latched on accepted start
//   o_quotient    quotient, held until the next result is written
//   o_remainder   remainder, held until the next result is written
//   o_busy        high while the divide is in progress
//   o_done        one-cycle pulse, results valid
//   o_div_zero    divisor was zero; valid with o_done, held like results
//   o_state       debug view of the FSM state (0 IDLE, 1 RUN, 2 FIX, 3 DONE)
//
// Handshake: i_start is a request with no back-pressure. It is taken only
// when the FSM is in IDLE, and it is ignored in every other state. o_done
// pulses for one cycle, exactly 34 clock edges after the accepting edge.
// o_busy covers the cycles in between, and o_busy and o_done never overlap.
//
// Timing note: o_busy and o_done are registered decodes of the FSM state.
// As a result they trail o_state by one cycle. After accepting edge T,
// o_busy is seen after edges T+1..T+33 and o_done after edge T+34.
// ---------------------------------------------------------------------------
module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sign,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dvd_raw;   // raw dividend, returned as remainder on /0
  logic [WIDTH-1:0] r_dvs;       // divisor magnitude
  logic [WIDTH-1:0] r_q;         // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] r_rem;       // partial remainder
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_fits;
  logic [WIDTH-1:0] w_diff;

  // Operand magnitudes. The magnitude of the most negative value is itself,
  // and that is the correct unsigned magnitude.
  assign w_dvd_abs = (i_sign && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
  assign w_dvs_abs = (i_sign && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

  // The shifted partial remainder is kept one bit wider. For an unsigned
  // divisor at or above 2^(WIDTH-1), the remainder can carry into bit WIDTH.
  // If the subtraction succeeds, the difference is below the divisor, so it
  // fits back into WIDTH bits.
  assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_dvs;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN:  if (r_count == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count     <= '0;
      r_dvd_raw   <= '0;
      r_dvs       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_busy <= (r_state == S_RUN) || (r_state == S_FIX);
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_dvd_raw <= i_dividend;
            r_q       <= w_dvd_abs;
            r_dvs     <= w_dvs_abs;
            r_rem     <= '0;
            r_neg_q   <= i_sign & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
            r_neg_r   <= i_sign & i_dividend[WIDTH-1];
            r_dz      <= (i_divisor == '0);
            r_count   <= '0;
          end
        end
        S_RUN: begin
          r_rem   <= w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
          r_q     <= {r_q[WIDTH-2:0], w_fits};
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          if (r_dz) begin
            r_quotient  <= '1;
            r_remainder <= r_dvd_raw;
            r_div_zero  <= 1'b1;
          end else begin
            r_quotient  <= r_neg_q ? -r_q : r_q;
            r_remainder <= r_neg_r ? -r_rem : r_rem;
            r_div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_div_zero  = r_div_zero;
  assign o_state     = r_state;

endmodule

// File: tb/tb_div_32.sv
// ---------------------------------------------------------------------------
// tb_div_32 : self-checking bench for div_32.
// Directed table of corner vectors, start-ignored and back-to-back
// sequences, mid-operation reset abort, and random signed and unsigned
// operations checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_div_32;

  localparam int W = 32;
  localparam int EXP_LAT = 34;
  localparam int N_RANDOM = 1500;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sign;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [1:0]   state;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected {quotient, remainder, div_zero}
  logic [2*W:0] exp_q[$];

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[13];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  div_32 #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_sign     (sign),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_quotient (quotient),
    .o_remainder(remainder),
    .o_busy     (busy),
    .o_done     (done),
    .o_div_zero (div_zero),
    .o_state    (state)
  );

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] ref_div(input logic s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    longint sa;
    longint sb;
    if (b == '0) return {{W{1'b1}}, a, 1'b1};
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = W'(sa / sb);   // truncates toward zero
      r  = W'(sa % sb);   // takes the dividend's sign
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r, 1'b0};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request and waits, with a bound, for done. Checks the
  // latency and the busy/done pattern. When poke > 0, start is re-asserted
  // at edge T+poke with scrambled operands, and those must be ignored.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke, output logic [2*W:0] got);
    int lat;
    int bad;
    @(negedge clk);
    sign = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    bad = 0;
    for (int k = 1; k <= EXP_LAT + 6; k++) begin
      if (k == poke) begin
        start = 1'b1; sign = ~s; dividend = $urandom; divisor = $urandom;
      end
      @(posedge clk);
      #1;
      if (k == poke) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) bad++;
    end
    if (done && busy) bad++;
    got = {quotient, remainder, div_zero};
    check("latency", 64'(lat), 64'(EXP_LAT));
    check("busy_pattern", 64'(bad), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin : main
    logic [2*W:0] got;
    logic [2*W:0] exp;
    logic         rs;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           seen_done;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    vecs[4]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
    vecs[5]  = '{1'b1, 32'hFFFFFF85,  32'd0,         32'hFFFFFFFF,  32'hFFFFFF85,  1'b1};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'h80000001,  32'd1,         32'h7FFFFFFE,  1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
    vecs[8]  = '{1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0};
    vecs[9]  = '{1'b0, 32'd0,         32'd0,         32'hFFFFFFFF,  32'd0,         1'b1};
    vecs[10] = '{1'b1, 32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[12] = '{1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0};

    // Reset state
    rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, 0, got);
      check($sformatf("vec%0d_quotient", i), 64'(got[2*W:W+1]), 64'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), 64'(got[W:1]), 64'(vecs[i].r));
      check($sformatf("vec%0d_div_zero", i), 64'(got[0]), 64'(vecs[i].dz));
    end

    // Start during RUN is ignored, then a back-to-back request is accepted
    run_op(1'b0, 32'd1000, 32'd3, 5, got);
    check("ignore_quotient", 64'(got[2*W:W+1]), 64'd333);
    check("ignore_remainder", 64'(got[W:1]), 64'd1);
    run_op(1'b1, 32'hFFFFFFB3, 32'd7, 0, got);   // -77 / 7
    check("b2b_quotient", 64'(got[2*W:W+1]), 64'(32'hFFFFFFF5));
    check("b2b_remainder", 64'(got[W:1]), 64'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    sign = 1'b0; dividend = 32'd12345; divisor = 32'd10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    check("abort_div_zero", 64'(div_zero), 64'd0);
    seen_done = 0;
    for (int k = 0; k < EXP_LAT + 6; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    run_op(1'b0, 32'd12345, 32'd10, 0, got);
    check("recover_result", 64'(got), 64'({32'd1234, 32'd5, 1'b0}));

    // Random regression against the reference model
    for (int n = 0; n < N_RANDOM; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = '1;
        2, 3:    rb = W'($urandom_range(1, 15));
        4:       rb = -W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 19) == 0) ra = 32'h80000000;
      exp_q.push_back(ref_div(rs, ra, rb));
      run_op(rs, ra, rb, 0, got);
      exp = exp_q.pop_front();
      if (got !== exp)
        $display("  operands sign=%0d a=%0h b=%0h", rs, ra, rb);
      check("random_result", 64'(got), 64'(exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
